apb_master_arb: RTL and testbench
=================================

APB_MASTER_ARB -- requirements
Module: apb_master_arb

Interface
REQ-001 Parameter ADDR_W, default 8, APB address width.
REQ-002 Parameter DATA_W, default 16, APB data width.
REQ-003 Parameter TIMEOUT, default 16, max ACCESS cycles waiting for pready; legal range >= 1.
REQ-004 pclk  input  1  clock; all state updates on rising edge.
REQ-005 rst  input  1  reset; asynchronous, active-low.
REQ-006 reqN (N=0,1)  input  1  requester N transfer request; level, held until doneN.
REQ-007 writeN  input  1  requester N direction: 1 write, 0 read.
REQ-008 addrN  input  ADDR_W  requester N target address.
REQ-009 wdataN  input  DATA_W  requester N write data.
REQ-010 doneN  output  1  one-cycle pulse: requester N transfer finished.
REQ-011 err  output  1  valid with any doneN: 1 = transfer aborted by timeout.
REQ-012 rdata  output  DATA_W  read data of last successful read.
REQ-013 psel, penable, pwrite  output  1 each  APB control to slave.
REQ-014 paddr  output  ADDR_W; pwdata  output  DATA_W  APB address/write data.
REQ-015 pready  input  1; prdata  input  DATA_W  APB slave response.

Function
REQ-016 FSM states IDLE, SETUP, ACCESS; all APB outputs, doneN, err, rdata registered.
REQ-017 IDLE: psel=0, penable=0; if any eligible reqN sampled high, latch that requester's write/addr/wdata, record grant, go SETUP.
REQ-018 Eligibility: a requester whose doneN is high in the current cycle is ignored that cycle.
REQ-019 Arbitration round-robin: both eligible -> grant the one not granted last; single eligible -> grant it; last-grant pointer resets to 1 (requester 0 wins first tie).
REQ-020 SETUP: exactly one cycle, psel=1, penable=0, pready ignored; go ACCESS.
REQ-021 ACCESS: psel=1, penable=1; paddr/pwdata/pwrite hold latched values, unchanged from SETUP to end of transfer.
REQ-022 ACCESS with pready=1: go IDLE; next cycle doneN=1, err=0; read -> rdata=prdata sampled on that edge; write -> rdata unchanged.
REQ-023 Wait counter clears on entering ACCESS, increments each ACCESS cycle with pready=0.
REQ-024 After TIMEOUT consecutive ACCESS cycles with pready=0: go IDLE, doneN=1, err=1, rdata unchanged.
REQ-025 Zero-wait latency: req sampled edge 0 -> SETUP cycle 1 -> ACCESS cycle 2 -> doneN cycle 3.
REQ-026 reqN/addrN/wdataN/writeN changes during SETUP/ACCESS ignored; only latched values drive the bus.
REQ-027 pwdata drives latched wdata for reads too (don't-care to slave); err=0 whenever no doneN asserted.

Reset
REQ-028 rst low, regardless of state: immediately state=IDLE, psel=penable=pwrite=0, paddr=0, pwdata=0, rdata=0, done0=done1=0, err=0, counter=0, pointer=1.
REQ-029 Transfer interrupted by reset produces no doneN; pending requests re-arbitrate after rst rises.

Verification
REQ-030 req0 write addr 0x05 wdata 0x1234, pready tied 1 -> psel rises cycle 1, penable cycle 2, done0 cycle 3, err=0, paddr=0x05, pwdata=0x1234, pwrite=1 throughout.
REQ-031 req1 read addr 0x05, slave returns 0x1234 after 2 wait states -> ACCESS lasts 3 cycles, done1 with rdata=0x1234, err=0.
REQ-032 req0 and req1 asserted together after reset and re-asserted after each done -> grants 0,1,0,1; no requester served twice in a row.
REQ-033 pready stuck 0, TIMEOUT=16 -> after 16 ACCESS cycles psel/penable drop, doneN=1 with err=1, rdata unchanged.
REQ-034 rst low mid-ACCESS -> psel/penable 0 same cycle, no doneN; after release held req0 served normally from IDLE.
REQ-035 Against the apbslave block: req0 writes addresses 0..255 with data=address, then reads 0..255 -> every read rdata equals address, err never set.

Source files
------------

// File: rtl/apb_master_arb_if.sv
// APB bus between the two-requester arbiter (master) and one slave.
// The master drives control, address and write data; the slave answers.
interface apb_master_arb_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
);
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic              pready;
    logic [DATA_W-1:0] prdata;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  pready, prdata
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output pready, prdata
    );
endinterface

// File: rtl/apb_master_arb.sv
// Two-requester round-robin APB master with a bounded ACCESS wait.
// All bus, done, err and rdata outputs come straight from flops.
module apb_master_arb #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 16
) (
    input  logic              pclk,
    input  logic              rst,
    input  logic              req0,
    input  logic              write0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    input  logic              req1,
    input  logic              write1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              done0,
    output logic              done1,
    output logic              err,
    output logic [DATA_W-1:0] rdata,
    apb_master_arb_if.master  apb
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETUP  = 2'd1;
    localparam logic [1:0] ACCESS = 2'd2;
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [1:0]        state_q, state_d;
    logic              psel_q, psel_d;
    logic              pen_q, pen_d;
    logic              pwrite_q, pwrite_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              done0_q, done0_d;
    logic              done1_q, done1_d;
    logic              err_q, err_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              last_q, last_d;
    logic              gnt_q, gnt_d;
    logic              elig0, elig1, pick1, fin;

    always_comb begin
        state_d  = state_q;
        psel_d   = psel_q;
        pen_d    = pen_q;
        pwrite_d = pwrite_q;
        paddr_d  = paddr_q;
        pwdata_d = pwdata_q;
        rdata_d  = rdata_q;
        cnt_d    = cnt_q;
        last_d   = last_q;
        gnt_d    = gnt_q;
        err_d    = 1'b0;
        fin      = 1'b0;
        // A requester being told "done" this cycle must not win again yet
        elig0 = req0 & ~done0_q;
        elig1 = req1 & ~done1_q;
        pick1 = elig1 & (~elig0 | ~last_q);
        unique case (state_q)
            IDLE: begin
                if (elig0 | elig1) begin
                    gnt_d    = pick1;
                    last_d   = pick1;
                    pwrite_d = pick1 ? write1 : write0;
                    paddr_d  = pick1 ? addr1 : addr0;
                    pwdata_d = pick1 ? wdata1 : wdata0;
                    psel_d   = 1'b1;
                    state_d  = SETUP;
                end
            end
            SETUP: begin
                pen_d   = 1'b1;
                cnt_d   = '0;
                state_d = ACCESS;
            end
            ACCESS: begin
                if (apb.pready) begin
                    fin = 1'b1;
                    if (!pwrite_q) rdata_d = apb.prdata;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    fin   = 1'b1;
                    err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (fin) begin
            state_d = IDLE;
            psel_d  = 1'b0;
            pen_d   = 1'b0;
        end
        done0_d = fin & ~gnt_q;
        done1_d = fin & gnt_q;
    end

    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            psel_q   <= 1'b0;
            pen_q    <= 1'b0;
            pwrite_q <= 1'b0;
            paddr_q  <= '0;
            pwdata_q <= '0;
            rdata_q  <= '0;
            done0_q  <= 1'b0;
            done1_q  <= 1'b0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
            last_q   <= 1'b1;
            gnt_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            psel_q   <= psel_d;
            pen_q    <= pen_d;
            pwrite_q <= pwrite_d;
            paddr_q  <= paddr_d;
            pwdata_q <= pwdata_d;
            rdata_q  <= rdata_d;
            done0_q  <= done0_d;
            done1_q  <= done1_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
            last_q   <= last_d;
            gnt_q    <= gnt_d;
        end
    end

    assign apb.psel    = psel_q;
    assign apb.penable = pen_q;
    assign apb.pwrite  = pwrite_q;
    assign apb.paddr   = paddr_q;
    assign apb.pwdata  = pwdata_q;
    assign done0       = done0_q;
    assign done1       = done1_q;
    assign err         = err_q;
    assign rdata       = rdata_q;
endmodule

// File: tb/tb_apb_master_arb.sv
// Directed bench for apb_master_arb with a small memory slave
// whose wait states can be set or stuck low.
module tb_apb_master_arb;
    logic        pclk = 1'b0;
    logic        rst = 1'b0;
    logic        req0 = 0, write0 = 0, req1 = 0, write1 = 0;
    logic [7:0]  addr0 = 0, addr1 = 0;
    logic [15:0] wdata0 = 0, wdata1 = 0;
    logic        done0, done1, err;
    logic [15:0] rdata;

    int checks = 0;
    int errors = 0;
    int wait_cfg = 0;
    bit stuck = 0;
    int wcnt = 0;
    logic [15:0] mem [256];

    apb_master_arb_if #(.ADDR_W(8), .DATA_W(16)) apb ();

    apb_master_arb #(.ADDR_W(8), .DATA_W(16), .TIMEOUT(16)) dut (
        .pclk(pclk), .rst(rst),
        .req0(req0), .write0(write0), .addr0(addr0), .wdata0(wdata0),
        .req1(req1), .write1(write1), .addr1(addr1), .wdata1(wdata1),
        .done0(done0), .done1(done1), .err(err), .rdata(rdata),
        .apb(apb.master)
    );

    always #5 pclk = ~pclk;

    assign apb.pready = !stuck && (wcnt >= wait_cfg);
    assign apb.prdata = mem[apb.paddr];

    always @(posedge pclk) begin
        if (apb.psel && apb.penable && !apb.pready) wcnt <= wcnt + 1;
        else wcnt <= 0;
        if (apb.psel && apb.penable && apb.pready && apb.pwrite)
            mem[apb.paddr] <= apb.pwdata;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic xfer(input int n, input bit wr, input logic [7:0] a,
                        input logic [15:0] d, output logic [15:0] rd,
                        output logic er, output int acc);
        bit got = 0;
        @(negedge pclk);
        if (n == 0) begin
            req0 = 1; write0 = wr; addr0 = a; wdata0 = d;
        end else begin
            req1 = 1; write1 = wr; addr1 = a; wdata1 = d;
        end
        acc = 0; rd = 'x; er = 'x;
        for (int k = 0; k < 100 && !got; k++) begin
            @(negedge pclk);
            if (apb.psel && apb.penable) acc++;
            if ((n == 0) ? done0 : done1) begin
                got = 1; rd = rdata; er = err;
            end
        end
        if (n == 0) req0 = 0; else req1 = 0;
        if (!got) chk("xfer_done", 32'(got), 1);
    endtask

    task automatic wait_done(output int who, output bit got);
        got = 0; who = -1;
        for (int k = 0; k < 30 && !got; k++) begin
            @(negedge pclk);
            if (done0 || done1) begin
                got = 1; who = done1 ? 1 : 0;
            end
        end
        if (!got) chk("done_wait", 32'(got), 1);
    endtask

    initial begin
        logic [15:0] rd;
        logic er;
        int acc, who, seen, bad;
        bit got;

        #2;
        chk("rst_psel", 32'(apb.psel), 0);
        chk("rst_pen", 32'(apb.penable), 0);
        chk("rst_pwrite", 32'(apb.pwrite), 0);
        chk("rst_paddr", 32'(apb.paddr), 0);
        chk("rst_pwdata", 32'(apb.pwdata), 0);
        chk("rst_rdata", 32'(rdata), 0);
        chk("rst_done", {30'd0, done1, done0}, 0);
        chk("rst_err", 32'(err), 0);
        @(negedge pclk); @(negedge pclk);
        rst = 1;

        // zero-wait write, cycle exact, request changes ignored
        @(negedge pclk);
        req0 = 1; write0 = 1; addr0 = 8'h05; wdata0 = 16'h1234;
        @(negedge pclk);
        chk("c1_psel", 32'(apb.psel), 1);
        chk("c1_pen", 32'(apb.penable), 0);
        addr0 = 8'hAA; wdata0 = 16'h0; write0 = 0;
        @(negedge pclk);
        chk("c2_psel", 32'(apb.psel), 1);
        chk("c2_pen", 32'(apb.penable), 1);
        chk("c2_paddr", 32'(apb.paddr), 32'h05);
        chk("c2_pwdata", 32'(apb.pwdata), 32'h1234);
        chk("c2_pwrite", 32'(apb.pwrite), 1);
        @(negedge pclk);
        chk("c3_done0", 32'(done0), 1);
        chk("c3_err", 32'(err), 0);
        chk("c3_psel", 32'(apb.psel), 0);
        req0 = 0;

        // read with two wait states
        wait_cfg = 2;
        xfer(1, 0, 8'h05, 16'h0, rd, er, acc);
        chk("rd_acc", 32'(acc), 3);
        chk("rd_data", 32'(rd), 32'h1234);
        chk("rd_err", 32'(er), 0);
        wait_cfg = 0;

        // both held: strict alternation starting from requester 0
        @(negedge pclk);
        req0 = 1; write0 = 1; addr0 = 8'h10; wdata0 = 16'h1111;
        req1 = 1; write1 = 1; addr1 = 8'h11; wdata1 = 16'h2222;
        for (int g = 0; g < 4; g++) begin
            wait_done(who, got);
            chk("rr_alt", 32'(who), 32'(g % 2));
            if (g == 3) begin
                req0 = 0; req1 = 0;
            end
        end
        chk("rr_mem0", 32'(mem[8'h10]), 32'h1111);
        chk("rr_mem1", 32'(mem[8'h11]), 32'h2222);
        @(negedge pclk);
        req0 = 1; req1 = 1;
        wait_done(who, got);
        req0 = 0; req1 = 0;
        chk("rr_after1", 32'(who), 0);
        xfer(0, 1, 8'h12, 16'h3333, rd, er, acc);
        @(negedge pclk);
        req0 = 1; req1 = 1;
        wait_done(who, got);
        req0 = 0; req1 = 0;
        chk("rr_after0", 32'(who), 1);

        // pready stuck low: timeout after 16 ACCESS cycles
        stuck = 1;
        xfer(0, 0, 8'h07, 16'h0, rd, er, acc);
        chk("to_acc", 32'(acc), 16);
        chk("to_err", 32'(er), 1);
        chk("to_rdata", 32'(rd), 32'h1234);
        chk("to_psel", 32'(apb.psel), 0);
        stuck = 0;
        @(negedge pclk);
        chk("to_err_clr", 32'(err), 0);

        // reset in the middle of ACCESS
        wait_cfg = 5;
        req0 = 1; write0 = 1; addr0 = 8'h33; wdata0 = 16'hBEEF;
        got = 0;
        for (int k = 0; k < 10 && !got; k++) begin
            @(negedge pclk);
            got = apb.psel && apb.penable;
        end
        chk("mr_access", 32'(got), 1);
        #1 rst = 0;
        #1;
        chk("mr_psel", 32'(apb.psel), 0);
        chk("mr_pen", 32'(apb.penable), 0);
        chk("mr_rdata", 32'(rdata), 0);
        seen = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge pclk);
            if (done0 || done1) seen++;
        end
        rst = 1;
        wait_done(who, got);
        chk("mr_nodone", 32'(seen), 0);
        chk("mr_who", 32'(who), 0);
        chk("mr_err", 32'(err), 0);
        req0 = 0;
        chk("mr_mem", 32'(mem[8'h33]), 32'hBEEF);

        // full address sweep: write address as data, read back
        bad = 0;
        for (int i = 0; i < 256; i++) begin
            wait_cfg = i % 3;
            xfer(0, 1, 8'(i), 16'(i), rd, er, acc);
            if (er !== 1'b0) bad++;
        end
        chk("sw_werr", 32'(bad), 0);
        for (int i = 0; i < 256; i++) begin
            wait_cfg = (i + 1) % 3;
            xfer(0, 0, 8'(i), 16'h0, rd, er, acc);
            chk("sw_rdata", 32'(rd), 32'(i));
            chk("sw_rerr", 32'(er), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got hang exp finish");
        $fatal(1);
    end
endmodule
